// File: rtl/mac512_result_unloader.sv
// MAC result unloader: snapshots the wide MAC result every MAC_CYCLES
// enabled cycles and streams it out LS word first over valid/ready.
module mac512_result_unloader #(
    parameter int RES_W      = 512,
    parameter int WORD_W     = 32,
    parameter int MAC_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mac_en,
    input  logic [RES_W-1:0]  mac_out,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       result_cnt
);

    localparam int NWORDS = RES_W / WORD_W;
    localparam int CW     = $clog2(MAC_CYCLES);
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sample_q, sample_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [RES_W-1:0]   buf_q, buf_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        rcnt_q, rcnt_d;

    logic               hs;
    logic               fin;
    logic               accept;
    logic [WORD_W-1:0]  word;

    // Handshake decode and capture acceptance for this edge
    always_comb begin
        hs     = (state_q == STREAM) && o_ready;
        fin    = hs && (idx_q == IW'(NWORDS - 1));
        accept = sample_q && ((state_q == IDLE) || fin);
    end

    // Next-state: cycle counter, capture, stream index, sticky overrun
    always_comb begin
        cnt_d     = cnt_q;
        sample_d  = 1'b0;
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        overrun_d = overrun_q;
        rcnt_d    = rcnt_q;

        if (mac_en) begin
            if (cnt_q == CW'(MAC_CYCLES - 1)) begin
                cnt_d    = '0;
                sample_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (hs) begin
            idx_d = idx_q + 1'b1;
            if (fin) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            buf_d   = mac_out;
            idx_d   = '0;
            state_d = STREAM;
            rcnt_d  = rcnt_q + 16'd1;
        end else if (sample_q) begin
            overrun_d = 1'b1;
        end
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sample_q  <= 1'b0;
            idx_q     <= '0;
            buf_q     <= '0;
            overrun_q <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            overrun_q <= overrun_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Word select from the held snapshot; depends only on flops
    always_comb begin
        word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_q == IW'(i)) begin
                word = buf_q[i*WORD_W +: WORD_W];
            end
        end
    end

    assign o_data     = word;
    assign o_valid    = (state_q == STREAM);
    assign busy       = (state_q == STREAM);
    assign o_last     = (state_q == STREAM) && (idx_q == IW'(NWORDS - 1));
    assign overrun    = overrun_q;
    assign result_cnt = rcnt_q;

endmodule

// File: tb/tb_mac512_result_unloader.sv
// Directed bench for mac512_result_unloader: table-driven basic stream
// plus hand-written backpressure, pause, overrun, collision and reset cases.
module tb_mac512_result_unloader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mac_en = 1'b0;
    logic [511:0] mac_out = '0;
    logic [31:0]  o_data;
    logic         o_valid;
    logic         o_ready = 1'b0;
    logic         o_last;
    logic         busy;
    logic         overrun;
    logic [15:0]  result_cnt;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [31:0] data;
        logic        last;
    } vec_t;

    vec_t tv [17];

    mac512_result_unloader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mac_en     (mac_en),
        .mac_out    (mac_out),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_last     (o_last),
        .busy       (busy),
        .overrun    (overrun),
        .result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        mac_en  = 1'b0;
        o_ready = 1'b0;
        mac_out = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " o_valid"}, 64'(o_valid), 64'd0);
        chk({nm, " o_data"}, 64'(o_data), 64'd0);
        chk({nm, " o_last"}, 64'(o_last), 64'd0);
        chk({nm, " busy"}, 64'(busy), 64'd0);
        chk({nm, " overrun"}, 64'(overrun), 64'd0);
        chk({nm, " result_cnt"}, 64'(result_cnt), 64'd0);
    endtask

    initial begin
        int k;
        int idx_m;
        logic pat [4];

        for (int i = 0; i < 17; i++) begin
            tv[i] = '{rdy: 1'b1, valid: 1'b1, data: 32'h0, last: 1'b0};
        end
        tv[0].data  = 32'h400;
        tv[15].last = 1'b1;
        tv[16].valid = 1'b0;

        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;

        // ---- reset state
        do_reset();
        chk_zero("reset");

        // ---- basic stream, table driven
        mac_out = 512'd1024;
        o_ready = 1'b1;
        mac_en  = 1'b1;
        ticks(256);
        chk("basic pre-capture valid", 64'(o_valid), 64'd0);
        ticks(1);
        chk("basic result_cnt", 64'(result_cnt), 64'd1);
        chk("basic busy", 64'(busy), 64'd1);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("basic[%0d] valid", i), 64'(o_valid),
                64'(tv[i].valid));
            if (tv[i].valid) begin
                chk($sformatf("basic[%0d] data", i), 64'(o_data),
                    64'(tv[i].data));
                chk($sformatf("basic[%0d] last", i), 64'(o_last),
                    64'(tv[i].last));
            end
            o_ready = tv[i].rdy;
            ticks(1);
        end
        chk("basic overrun", 64'(overrun), 64'd0);

        // ---- backpressure with ready pattern 1,0,0,1
        do_reset();
        mac_out = {64{8'h0F}};
        mac_en  = 1'b1;
        ticks(257);
        mac_en = 1'b0;
        idx_m  = 0;
        k      = 0;
        while (idx_m < 16 && k < 100) begin
            chk("bp valid", 64'(o_valid), 64'd1);
            chk("bp data", 64'(o_data), 64'h0F0F0F0F);
            chk("bp last", 64'(o_last), 64'(idx_m == 15));
            o_ready = pat[k % 4];
            ticks(1);
            if (o_ready) idx_m++;
            k++;
        end
        chk("bp words drained", 64'(idx_m), 64'd16);
        chk("bp idle after drain", 64'(o_valid), 64'd0);

        // ---- pause of 10 cycles at cnt=100
        do_reset();
        mac_out = 512'd7;
        o_ready = 1'b1;
        mac_en  = 1'b1;
        ticks(100);
        mac_en = 1'b0;
        ticks(10);
        mac_en = 1'b1;
        ticks(156);
        chk("pause edge 266 valid", 64'(o_valid), 64'd0);
        ticks(1);
        chk("pause edge 267 valid", 64'(o_valid), 64'd1);
        chk("pause data", 64'(o_data), 64'd7);

        // ---- overrun: second result dropped while first is held
        do_reset();
        mac_out = 512'd50;
        mac_en  = 1'b1;
        ticks(257);
        chk("ovr first valid", 64'(o_valid), 64'd1);
        mac_out = 512'd5000;
        ticks(255);
        chk("ovr before drop", 64'(overrun), 64'd0);
        ticks(1);
        chk("ovr flag", 64'(overrun), 64'd1);
        chk("ovr result_cnt", 64'(result_cnt), 64'd1);
        chk("ovr held data", 64'(o_data), 64'd50);
        mac_en  = 1'b0;
        o_ready = 1'b1;
        ticks(1);
        chk("ovr word1", 64'(o_data), 64'd0);
        ticks(15);
        chk("ovr drained", 64'(o_valid), 64'd0);
        chk("ovr sticky", 64'(overrun), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst overrun", 64'(overrun), 64'd0);
        chk("async rst result_cnt", 64'(result_cnt), 64'd0);

        // ---- collision: final handshake on the capture edge
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mac_out[i*32 +: 32] = 32'h100 + 32'(i);
        end
        mac_en = 1'b1;
        ticks(257);
        chk("col A word0", 64'(o_data), 64'h100);
        ticks(240);
        o_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mac_out[i*32 +: 32] = 32'h200 + 32'(i);
        end
        ticks(1);
        chk("col A word1", 64'(o_data), 64'h101);
        ticks(14);
        chk("col A last", 64'(o_last), 64'd1);
        chk("col A word15", 64'(o_data), 64'h10F);
        ticks(1);
        chk("col B valid", 64'(o_valid), 64'd1);
        chk("col B word0", 64'(o_data), 64'h200);
        chk("col B last", 64'(o_last), 64'd0);
        chk("col result_cnt", 64'(result_cnt), 64'd2);
        chk("col overrun", 64'(overrun), 64'd0);
        ticks(1);
        chk("col B word1", 64'(o_data), 64'h201);

        // ---- reset mid-stream clears outputs without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid-stream reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
